decode_h2_pipe: RTL
===================

Name: decode_h2_pipe

Overview:
- Pipelined SEC-DED decoder for the 16-bit (H2) Hamming codeword.
- Sits directly downstream of the H2 encoder on the read path: accepts a stored or transmitted codeword, computes the syndrome, corrects single-bit errors and flags double-bit errors.
- Uses a valid/ready handshake so it can be back-pressured by the consumer.
- Keeps saturating error statistics.

Parameters:
- CNT_WIDTH, 16, width of each error-statistics counter.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- in_codeword  in  16  [15:5] = data[10:0]; [3:0] = Hamming parity p3..p0; [4] = overall parity.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  11  corrected data; raw data on double error.
- out_single_err  out  1  single error detected and corrected.
- out_double_err  out  1  uncorrectable double error.
- out_syndrome  out  4  Hamming position of the flipped bit (1..15); 0 = none or overall-parity bit.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_WIDTH  single-error count.
- ded_cnt  out  CNT_WIDTH  double-error count.

Behaviour:
- Reset (async, active-high): all pipeline valids = 0, all output registers = 0, counters = 0. Reset mid-transfer drops in-flight words; no partial output.
- Transfer rule: a word is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
- Stage 1 (S1) registers:
  - received codeword
  - syndrome s[3:0] = recomputed p[3:0] XOR received p[3:0], using p0 over data {0,1,3,4,6,8,10}, p1 over {0,2,3,5,6,9,10}, p2 over {1,2,3,7,8,9,10}, p3 over {4..10}
  - overall mismatch om = XOR of all 16 received bits
- Stage 2 (S2) classification:
  - s==0, om==0: clean.
  - om==1: single error. Flip the codeword bit at Hamming position s. Position map: 1→cw[0], 2→cw[1], 4→cw[2], 8→cw[3], s==0→cw[4]; data positions 3,5,6,7,9..15 → cw[5..15] in order.
  - s!=0, om==0: double error. Output raw data, no correction.
- Latency: 2 cycles from accepted input to out_valid, with no back-pressure. Throughput is one word per cycle.
- Back-pressure:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational, no skid buffer)
  - While out_valid && !out_ready, all out_* signals are held stable.
- Counters:
  - Each counter increments once per delivered word with the matching flag; it is not incremented while the word is stalled in S2.
  - Counters saturate at all-ones.
  - cnt_clr in the same cycle as an increment: clear wins, result 0.
- No cycle is wasted when the pipeline is full and out_ready stays high.

Optional Feature:
- DECODE_H2_ERR_INJECT_EN
- When defined, adds ports inj_en (in, 1) and inj_mask (in, 16). While inj_en=1, in_codeword is XORed with inj_mask at S1 capture.
- When undefined, the ports do not exist and the codeword is captured unmodified.
- Decode, latency and handshake are identical in both builds.

Decomposition:
- Shared package decode_h2_pkg holds:
  - data/codeword/syndrome width constants (11/16/4)
  - the four parity coverage masks as 11-bit localparams
  - an enum err_kind_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}
  - a function mapping Hamming position to codeword index
- One natural sub-module: decode_h2_syndrome. It is purely combinational: codeword in, s[3:0] and om out, instantiated at S1.

Test Plan:
1. Reset then in_codeword=16'hFFFF (data 11'h7FF) with out_ready=1 → out_valid 2 cycles later; out_data=11'h7FF; both flags 0; out_syndrome=0.
2. 16'h0020 (data bit0 flipped from 16'h0000) → out_data=11'h000, out_single_err=1, out_syndrome=3, sec_cnt=1.
3. 16'hFFEF (overall parity bit flipped) → out_data=11'h7FF, out_single_err=1, out_syndrome=0.
4. 16'h0003 (p0 and p1 flipped) → out_double_err=1, out_data=11'h000, out_syndrome=3, ded_cnt=1, sec_cnt unchanged.
5. Stream 4 words with out_ready low for 3 cycles mid-stream → in_ready drops after 2 words are buffered; out_* held stable; all 4 words delivered in order, no loss or duplication; counters count each error once.
6. Assert cnt_clr in the same cycle a single-error word is delivered → sec_cnt=0. Assert rst mid-stream → out_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/decode_h2_pkg.sv
// decode_h2_pkg: shared widths, parity coverage masks, error classes and the
// Hamming-position to codeword-index mapping for the H2 SEC-DED decoder.
package decode_h2_pkg;

    localparam int DATA_W = 11;
    localparam int CW_W   = 16;
    localparam int SYN_W  = 4;

    // Data bits covered by each Hamming parity bit (bit n of a mask = data[n])
    localparam logic [DATA_W-1:0] P0_MASK = 11'h55B;  // data {0,1,3,4,6,8,10}
    localparam logic [DATA_W-1:0] P1_MASK = 11'h66D;  // data {0,2,3,5,6,9,10}
    localparam logic [DATA_W-1:0] P2_MASK = 11'h78E;  // data {1,2,3,7,8,9,10}
    localparam logic [DATA_W-1:0] P3_MASK = 11'h7F0;  // data {4..10}

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_kind_t;

    // Position 0 stands for the overall-parity bit; parity positions 1,2,4,8
    // live in cw[3:0]; the remaining positions hold data in cw[15:5] in order.
    function automatic logic [3:0] pos_to_idx(input logic [SYN_W-1:0] pos);
        logic [3:0] idx;
        case (pos)
            4'd0:    idx = 4'd4;
            4'd1:    idx = 4'd0;
            4'd2:    idx = 4'd1;
            4'd3:    idx = 4'd5;
            4'd4:    idx = 4'd2;
            4'd5:    idx = 4'd6;
            4'd6:    idx = 4'd7;
            4'd7:    idx = 4'd8;
            4'd8:    idx = 4'd3;
            default: idx = pos;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/decode_h2_syndrome.sv
// decode_h2_syndrome: purely combinational syndrome and overall-mismatch
// computation for one 16-bit H2 codeword.
module decode_h2_syndrome
    import decode_h2_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [SYN_W-1:0] syndrome,
    output logic             om
);

    logic [DATA_W-1:0] data;

    assign data = codeword[CW_W-1:CW_W-DATA_W];

    // Recompute each parity over its coverage set and compare with the stored bit
    always_comb begin
        syndrome[0] = (^(data & P0_MASK)) ^ codeword[0];
        syndrome[1] = (^(data & P1_MASK)) ^ codeword[1];
        syndrome[2] = (^(data & P2_MASK)) ^ codeword[2];
        syndrome[3] = (^(data & P3_MASK)) ^ codeword[3];
        om          = ^codeword;
    end

endmodule

// File: rtl/decode_h2_pipe.sv
// decode_h2_pipe: two-stage SEC-DED decoder for the H2 codeword with a
// valid/ready handshake and saturating error counters.
// Optional build macro DECODE_H2_ERR_INJECT_EN adds inj_en/inj_mask ports that
// XOR a mask into the codeword as it is captured into the first stage.
module decode_h2_pipe
    import decode_h2_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_W-1:0]      in_codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_single_err,
    output logic                 out_double_err,
    output logic [SYN_W-1:0]     out_syndrome,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] sec_cnt,
    output logic [CNT_WIDTH-1:0] ded_cnt
`ifdef DECODE_H2_ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [CW_W-1:0]      inj_mask
`endif
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_om;

    logic              s1_adv;
    logic              s2_adv;
    logic              deliver;

    logic [CW_W-1:0]   cap_cw;
    logic [SYN_W-1:0]  cap_syn;
    logic              cap_om;

    err_kind_t         kind;
    logic [3:0]        flip_idx;
    logic [3:0]        data_idx;
    logic [DATA_W-1:0] fixed_data;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign deliver  = out_valid && out_ready;

`ifdef DECODE_H2_ERR_INJECT_EN
    assign cap_cw = inj_en ? (in_codeword ^ inj_mask) : in_codeword;
`else
    assign cap_cw = in_codeword;
`endif

    decode_h2_syndrome u_syndrome (
        .codeword (cap_cw),
        .syndrome (cap_syn),
        .om       (cap_om)
    );

    // Stage 1 captures data bits, syndrome and overall mismatch whenever it can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_om    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= cap_cw[CW_W-1:CW_W-DATA_W];
                s1_syn  <= cap_syn;
                s1_om   <= cap_om;
            end
        end
    end

    // Classify the stage-1 word; only a flip landing in cw[15:5] changes the data
    always_comb begin
        kind       = ERR_NONE;
        fixed_data = s1_data;
        flip_idx   = pos_to_idx(s1_syn);
        data_idx   = flip_idx - 4'd5;
        if (s1_om) begin
            kind = ERR_SINGLE;
            if (flip_idx >= 4'd5) begin
                fixed_data[data_idx] = ~s1_data[data_idx];
            end
        end else if (s1_syn != '0) begin
            kind = ERR_DOUBLE;
        end
    end

    // Stage 2 output registers hold their value while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
            out_syndrome   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data       <= fixed_data;
                out_single_err <= (kind == ERR_SINGLE);
                out_double_err <= (kind == ERR_DOUBLE);
                out_syndrome   <= s1_syn;
            end
        end
    end

    // Saturating statistics counted once per delivered word; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (deliver) begin
            if (out_single_err && (sec_cnt != '1)) begin
                sec_cnt <= sec_cnt + 1'b1;
            end
            if (out_double_err && (ded_cnt != '1)) begin
                ded_cnt <= ded_cnt + 1'b1;
            end
        end
    end

endmodule
